hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It replaces the per-stage register-compare logic with a per-register scoreboard that tracks the age and kind of every in-flight write. It generates the ID-stage stall and registered EX-stage forwarding selects. The load-to-use depth is configurable (`LOAD_EXTRA`), so deeper memory stages need no rewrite. It sits beside the ID/EX pipeline register, fed by the decoder, and drives the EX forwarding muxes.

---
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard and forwarding controller for the in-order pipeline.
// Each architectural register (except $0) tracks whether a write is in flight,
// how many cycles old that producer is, and whether it is a load.
module hazard_scoreboard #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LOAD_EXTRA = 1,
  localparam int unsigned NREGS     = 2 ** ADDR_W,
  localparam int unsigned RETIRE    = 2 + LOAD_EXTRA,
  localparam int unsigned SEL_W     = $clog2(RETIRE + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  ex_fwd_a,
  output logic [SEL_W-1:0]  ex_fwd_b,
  output logic [NREGS-1:0]  busy
);

  localparam logic [SEL_W-1:0] AgeOne    = SEL_W'(1);
  localparam logic [SEL_W-1:0] AgeRetire = SEL_W'(RETIRE);
  // Producer age seen from EX can reach RETIRE+1, so it gets one extra bit.
  localparam logic [SEL_W:0]   NOne      = (SEL_W + 1)'(1);
  localparam logic [SEL_W:0]   NRetire   = (SEL_W + 1)'(RETIRE);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] load_q, load_d;
  logic [SEL_W-1:0] age_q [NREGS];
  logic [SEL_W-1:0] age_d [NREGS];
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

  logic [SEL_W:0]   n_rs, n_rt;
  logic             hit_rs, hit_rt;
  logic             haz_rs, haz_rt;
  logic [SEL_W-1:0] sel_rs, sel_rt;
  logic             advance;
  logic             issue;

  // Evaluate each source against the scoreboard: producer age at consumer EX.
  always_comb begin
    n_rs   = {1'b0, age_q[id_rs]} + NOne;
    hit_rs = id_uses_rs && (id_rs != '0) && busy_q[id_rs];
    haz_rs = hit_rs && load_q[id_rs] && (n_rs < NRetire);
    sel_rs = (hit_rs && (n_rs <= NRetire)) ? n_rs[SEL_W-1:0] : '0;
    n_rt   = {1'b0, age_q[id_rt]} + NOne;
    hit_rt = id_uses_rt && (id_rt != '0) && busy_q[id_rt];
    haz_rt = hit_rt && load_q[id_rt] && (n_rt < NRetire);
    sel_rt = (hit_rt && (n_rt <= NRetire)) ? n_rt[SEL_W-1:0] : '0;
  end

  // Flush wins over stall; only an advancing instruction is recorded.
  assign stall   = id_valid && !flush && (haz_rs || haz_rt);
  assign advance = id_valid && !flush && !stall;
  assign issue   = advance && id_reg_write && (id_rd != '0);

  // Forward selects follow the instruction into EX; bubbles forward nothing.
  always_comb begin
    fwd_a_d = advance ? sel_rs : '0;
    fwd_b_d = advance ? sel_rt : '0;
  end

  // Age busy entries, retire the oldest, then let a new issue override its index.
  always_comb begin
    busy_d = busy_q;
    load_d = load_q;
    age_d  = age_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (busy_q[r]) begin
        if (age_q[r] == AgeRetire) begin
          busy_d[r] = 1'b0;
          load_d[r] = 1'b0;
          age_d[r]  = '0;
        end else begin
          age_d[r] = age_q[r] + AgeOne;
        end
      end
    end
    if (issue) begin
      busy_d[id_rd] = 1'b1;
      load_d[id_rd] = id_is_load;
      age_d[id_rd]  = AgeOne;
    end
  end

  // Scoreboard and forwarding-select state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_q  <= '0;
      load_q  <= '0;
      age_q   <= '{default: '0};
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      busy_q  <= busy_d;
      load_q  <= load_d;
      age_q   <= age_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_EXTRA 1 and 3) share stimulus.
// The reference model records the issue cycle of the youngest producer per
// register and derives age and hazards from elapsed time.
module tb_hazard_scoreboard;

  localparam int LE0 = 1;
  localparam int LE1 = 3;

  logic        Clk;
  logic        Reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_is_load;
  logic        flush;

  logic        stall0, stall1;
  logic [1:0]  fwd_a0, fwd_b0;
  logic [2:0]  fwd_a1, fwd_b1;
  logic [31:0] busy0, busy1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc = 0;
  int          t_m  [2][32];
  bit          v_m  [2][32];
  bit          ld_m [2][32];
  logic [31:0] exp_fa [2];
  logic [31:0] exp_fb [2];

  hazard_scoreboard #(.ADDR_W(5), .LOAD_EXTRA(LE0)) dut0 (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_rd(id_rd), .flush(flush), .stall(stall0),
    .ex_fwd_a(fwd_a0), .ex_fwd_b(fwd_b0), .busy(busy0)
  );

  hazard_scoreboard #(.ADDR_W(5), .LOAD_EXTRA(LE1)) dut1 (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_rd(id_rd), .flush(flush), .stall(stall1),
    .ex_fwd_a(fwd_a1), .ex_fwd_b(fwd_b1), .busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int ret(int d);
    return 2 + ((d == 0) ? LE0 : LE1);
  endfunction

  // Age of the live producer of r (1 = in EX), or 0 when nothing is pending.
  function automatic int m_age(int d, int r);
    int a;
    if (r == 0 || !v_m[d][r]) return 0;
    a = cyc - t_m[d][r] + 1;
    return (a >= 1 && a <= ret(d)) ? a : 0;
  endfunction

  function automatic bit m_haz(int d, int s, bit uses);
    int a = m_age(d, s);
    return uses && a > 0 && ld_m[d][s] && (a + 1 < ret(d));
  endfunction

  function automatic int m_sel(int d, int s, bit uses);
    int a = m_age(d, s);
    return (uses && a > 0 && a + 1 <= ret(d)) ? a + 1 : 0;
  endfunction

  function automatic bit m_stall(int d);
    return id_valid && !flush && (m_haz(d, id_rs, id_uses_rs) || m_haz(d, id_rt, id_uses_rt));
  endfunction

  function automatic logic [31:0] m_mask(int d);
    logic [31:0] m = '0;
    for (int r = 0; r < 32; r++) m[r] = (m_age(d, r) > 0);
    return m;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) v_m[d][r] = 1'b0;
      exp_fa[d] = '0;
      exp_fb[d] = '0;
    end
  endtask

  // One clock edge: predict registered selects and record issues in the model.
  task automatic tick();
    bit adv;
    bit iss [2];
    for (int d = 0; d < 2; d++) begin
      adv       = id_valid && !flush && !m_stall(d);
      exp_fa[d] = adv ? m_sel(d, id_rs, id_uses_rs) : 0;
      exp_fb[d] = adv ? m_sel(d, id_rt, id_uses_rt) : 0;
      iss[d]    = adv && id_reg_write && (id_rd != 0);
    end
    @(posedge Clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (iss[d]) begin
        t_m[d][id_rd]  = cyc;
        v_m[d][id_rd]  = 1'b1;
        ld_m[d][id_rd] = id_is_load;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, int rs, bit urs, int rt, bit urt, bit wr, bit ld, int rd, bit fl);
    id_valid     = v;
    id_rs        = 5'(rs);
    id_uses_rs   = urs;
    id_rt        = 5'(rt);
    id_uses_rt   = urt;
    id_reg_write = wr;
    id_is_load   = ld;
    id_rd        = 5'(rd);
    flush        = fl;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    // Out of power-on reset
    checks++;
    if (busy0 !== 32'h0 || stall0 !== 1'b0 || fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_init: busy=%h stall=%b fa=%0d fb=%0d, want all 0",
               busy0, stall0, fwd_a0, fwd_b0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    // Build three busy entries and a pending load-use hazard
    drive(1, 0, 0, 0, 0, 1, 0, 7, 0); tick();
    drive(1, 7, 1, 0, 0, 1, 0, 8, 0); tick();
    drive(1, 8, 1, 0, 0, 1, 1, 3, 0); tick();
    drive(1, 3, 1, 0, 0, 1, 0, 9, 0);
    #1;
    checks++;
    if (busy0 !== 32'h0000_0188 || stall0 !== 1'b1 || fwd_a0 !== 2'd2) begin
      errors++;
      $display("FAIL reset_setup: busy=%h stall=%b fa=%0d, want 00000188 1 2",
               busy0, stall0, fwd_a0);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (busy0 !== 32'h0 || stall0 !== 1'b0 || fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_async0: busy=%h stall=%b fa=%0d fb=%0d, want all 0",
               busy0, stall0, fwd_a0, fwd_b0);
    end
    checks++;
    if (busy1 !== 32'h0 || stall1 !== 1'b0 || fwd_a1 !== 3'd0 || fwd_b1 !== 3'd0) begin
      errors++;
      $display("FAIL reset_async1: busy=%h stall=%b fa=%0d fb=%0d, want all 0",
               busy1, stall1, fwd_a1, fwd_b1);
    end
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ALU producer followed by a consumer after 0, 1 and 2 gap instructions.
  task automatic test_alu_forward();
    logic [1:0] want0 [3];
    logic [2:0] want1 [3];
    want0 = '{2'd2, 2'd3, 2'd0};
    want1 = '{3'd2, 3'd3, 3'd4};
    for (int gaps = 0; gaps < 3; gaps++) begin
      drain();
      drive(1, 1, 1, 2, 1, 1, 0, 3, 0); tick();
      for (int g = 0; g < gaps; g++) begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      end
      drive(1, 3, 1, 4, 1, 1, 0, 5, 0);
      #1;
      checks++;
      if (stall0 !== 1'b0 || stall1 !== 1'b0) begin
        errors++;
        $display("FAIL alu_nostall gaps=%0d: stall0=%b stall1=%b, want 0 0", gaps, stall0, stall1);
      end
      tick();
      checks++;
      if (fwd_a0 !== want0[gaps] || fwd_b0 !== 2'd0) begin
        errors++;
        $display("FAIL alu_fwd0 gaps=%0d: fa=%0d fb=%0d, want %0d 0",
                 gaps, fwd_a0, fwd_b0, want0[gaps]);
      end
      checks++;
      if (fwd_a1 !== want1[gaps]) begin
        errors++;
        $display("FAIL alu_fwd1 gaps=%0d: fa=%0d, want %0d", gaps, fwd_a1, want1[gaps]);
      end
    end
  endtask

  // lw $3 then add $6,$3,$3 held in ID until it advances.
  task automatic test_load_use();
    logic       st0 [6];
    logic       st1 [6];
    logic [1:0] fa0 [6];
    logic [1:0] fb0 [6];
    logic [2:0] fa1 [6];
    logic [2:0] fb1 [6];
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0); tick();
    drive(1, 3, 1, 3, 1, 1, 0, 6, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      st0[i] = stall0;
      st1[i] = stall1;
      tick();
      fa0[i] = fwd_a0; fb0[i] = fwd_b0;
      fa1[i] = fwd_a1; fb1[i] = fwd_b1;
    end
    checks++;
    if (st0[0] !== 1'b1 || st0[1] !== 1'b0) begin
      errors++;
      $display("FAIL load_stall0: stall pattern %b%b, want 10", st0[0], st0[1]);
    end
    checks++;
    if (fa0[0] !== 2'd0 || fb0[0] !== 2'd0) begin
      errors++;
      $display("FAIL load_bubble0: fa=%0d fb=%0d, want 0 0", fa0[0], fb0[0]);
    end
    checks++;
    if (fa0[1] !== 2'd3 || fb0[1] !== 2'd3) begin
      errors++;
      $display("FAIL load_fwd0: fa=%0d fb=%0d, want 3 3", fa0[1], fb0[1]);
    end
    checks++;
    if (st1[0] !== 1'b1 || st1[1] !== 1'b1 || st1[2] !== 1'b1 || st1[3] !== 1'b0) begin
      errors++;
      $display("FAIL load_stall1: stall pattern %b%b%b%b, want 1110",
               st1[0], st1[1], st1[2], st1[3]);
    end
    checks++;
    if (fa1[3] !== 3'd5 || fb1[3] !== 3'd5 || fa1[2] !== 3'd0) begin
      errors++;
      $display("FAIL load_fwd1: fa=%0d fb=%0d (prev fa=%0d), want 5 5 (0)",
               fa1[3], fb1[3], fa1[2]);
    end
  endtask

  // lw $3 replaced by addi $3 the next cycle: reader sees an ALU producer.
  task automatic test_back_to_back();
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0); tick();
    drive(1, 1, 1, 0, 0, 1, 0, 3, 0); tick();
    drive(1, 3, 1, 0, 0, 1, 0, 6, 0);
    #1;
    checks++;
    if (stall0 !== 1'b0 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL reissue_stall: stall0=%b stall1=%b, want 0 0", stall0, stall1);
    end
    tick();
    checks++;
    if (fwd_a0 !== 2'd2 || fwd_a1 !== 3'd2) begin
      errors++;
      $display("FAIL reissue_fwd: fa0=%0d fa1=%0d, want 2 2", fwd_a0, fwd_a1);
    end
  endtask

  // Load-use hazard squashed by a flush in the same cycle.
  task automatic test_flush();
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0); tick();
    drive(1, 3, 1, 3, 1, 1, 0, 6, 1);
    #1;
    checks++;
    if (stall0 !== 1'b0 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall0=%b stall1=%b, want 0 0", stall0, stall1);
    end
    tick();
    checks++;
    if (fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0 || busy0 !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_drop: fa=%0d fb=%0d busy=%h, want 0 0 00000008",
               fwd_a0, fwd_b0, busy0);
    end
  endtask

  // $0 is never tracked and never forwarded.
  task automatic test_zero_reg();
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    checks++;
    if (busy0 !== 32'h0 || busy1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_busy: busy0=%h busy1=%h, want 0 0", busy0, busy1);
    end
    drive(1, 0, 1, 0, 1, 1, 0, 1, 0);
    #1;
    checks++;
    if (stall0 !== 1'b0 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_stall: stall0=%b stall1=%b, want 0 0", stall0, stall1);
    end
    tick();
    checks++;
    if (fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0 || busy0 !== 32'h0000_0002) begin
      errors++;
      $display("FAIL zero_fwd: fa=%0d fb=%0d busy=%h, want 0 0 00000002", fwd_a0, fwd_b0, busy0);
    end
  endtask

  // Random instruction stream over a small register window, with rare resets.
  task automatic test_random();
    drain();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 85), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 40), $urandom_range(0, 7), ($urandom_range(0, 99) < 10));
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (((d == 0) ? stall0 : stall1) !== m_stall(d)) begin
          errors++;
          $display("FAIL rnd_stall%0d cyc=%0d: got %b, want %b",
                   d, cyc, (d == 0) ? stall0 : stall1, m_stall(d));
        end
        checks++;
        if (((d == 0) ? busy0 : busy1) !== m_mask(d)) begin
          errors++;
          $display("FAIL rnd_busy%0d cyc=%0d: got %h, want %h",
                   d, cyc, (d == 0) ? busy0 : busy1, m_mask(d));
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (busy0 !== 32'h0 || busy1 !== 32'h0 || stall0 !== 1'b0 || stall1 !== 1'b0) begin
          errors++;
          $display("FAIL rnd_reset: busy0=%h busy1=%h stall0=%b stall1=%b, want 0",
                   busy0, busy1, stall0, stall1);
        end
        @(negedge Clk);
        Reset = 1'b0;
        continue;
      end
      tick();
      checks++;
      if (32'(fwd_a0) !== exp_fa[0] || 32'(fwd_b0) !== exp_fb[0]) begin
        errors++;
        $display("FAIL rnd_fwd0 cyc=%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                 cyc, fwd_a0, fwd_b0, exp_fa[0], exp_fb[0]);
      end
      checks++;
      if (32'(fwd_a1) !== exp_fa[1] || 32'(fwd_b1) !== exp_fb[1]) begin
        errors++;
        $display("FAIL rnd_fwd1 cyc=%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                 cyc, fwd_a1, fwd_b1, exp_fa[1], exp_fb[1]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
